pk_t1_pack_ctrl: RTL and testbench
==================================

Name: pk_t1_pack_ctrl

Overview:
Sequencer that serialises K packed t1 polynomials for public-key encoding.
- Reads 32-bit coefficients from a polynomial RAM, four at a time.
- Packs each group of four 10-bit values into 5 bytes using the t1 bit layout.
- Streams the bytes over a valid/ready byte interface.
- Sits between the t1 coefficient RAM and the pk/hash byte sink. Prefetches the next group while the current group drains, so it sustains 1 byte/cycle.

Parameters:
- K, 4, number of polynomials to pack (one pass emits K*320 bytes).
- AW, 10, RAM address width; must be >= clog2(K*256).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte is accepted.
- coef_rd_en  out  1  RAM read strobe.
- coef_rd_addr  out  AW  RAM address; coefficient j of poly p is at p*256+j.
- coef_rd_data  in  32  read data, valid exactly 1 cycle after coef_rd_en.
- out_data  out  8  packed byte.
- out_valid  out  1  byte available.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready.
- err  out  1  sticky range error (only with the optional feature).

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM=IDLE; counters, group registers and staging valid flags cleared. Reset mid-pass aborts the pass; no done is generated.
- FSM states:
  - IDLE: start -> FETCH. start while busy is ignored.
  - FETCH: issues 4 consecutive reads (addr, addr+1, addr+2, addr+3), then captures the 4 returned low-10-bit values into the staging register; staging_full=1.
  - EMIT: the byte register holds a 40-bit packed group and emits bytes 0..4 in order.
  - DRAIN: no more reads; remaining bytes are emitted.
  - DONE: pulse done, -> IDLE.
- Group register loads from staging when empty (or when byte 4 is accepted) and staging_full=1. While EMIT is active, the next group's 4 reads are issued if staging is free or will be freed.
- Packing (a0..a3 = coef[9:0]):
  - b0 = a0[7:0]
  - b1 = {a1[5:0], a0[9:8]}
  - b2 = {a2[3:0], a1[9:6]}
  - b3 = {a3[1:0], a2[9:4]}
  - b4 = a3[9:2]
  - Bits [31:10] of each coefficient are ignored.
- Handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid never drops without acceptance.
  - No byte is duplicated or skipped.
- Order: poly 0..K-1, coefficient ascending, 64 groups per poly. Address wraps only at pass end (last addr K*256-1).
- Latency: start accepted at cycle 0 -> first coef_rd_en at cycle 1 -> first out_valid at cycle 6. With out_ready held high: one byte per cycle, done at cycle 6+K*320.
- Backpressure: the read pipeline stalls when staging is full and the group register is busy. Read data in flight is always captured (never dropped).
- done and busy=0 are asserted the cycle after the final b4 handshake. start in the same cycle as done is ignored.

Optional Feature:
- Macro T1_RANGE_CHECK_EN.
  - Defined: any captured coefficient with bits [31:10] != 0 sets err. err is sticky until the next accepted start or reset. Packing continues unchanged (truncated value).
  - Undefined: err tied to 0; no comparison logic.

Decomposition:
- Shared package: N=256, T1_BITS=10, T1_GROUP=4, T1_GROUP_BYTES=5, T1_POLY_BYTES=320, FSM state enum.
- One sub-module: t1_group_pack, combinational 4x10-bit -> 40-bit packer implementing the byte equations above. The controller instantiates it on the staging register output.

Test Plan:
- K=1, all coefficients 0x3FF, out_ready=1 -> 320 bytes of 0xFF, consecutive cycles 6..325; done at 326.
- Group coefficients 1,2,3,4 -> bytes 0x01,0x08,0x30,0x00,0x01; coefficient j=ascending index -> byte stream matches the software polyt1_pack model for K=4 (1280 bytes).
- out_ready random 30% duty -> identical 1280-byte stream; out_data stable during stalls; coef_rd_addr never skips or repeats.
- rst_n low after byte 100 -> all outputs 0 asynchronously; new start -> full correct stream from addr 0; no stale done.
- start pulsed while busy, and in the done cycle -> ignored; exactly one done per pass.
- T1_RANGE_CHECK_EN defined, coefficient 0x400 at addr 5 -> err=1 from the cycle after capture; byte for that coefficient uses 0x000; err clears on next start.

Source files
------------

// File: rtl/pk_t1_pack_ctrl_pkg.sv
// pk_t1_pack_ctrl_pkg: shared constants and FSM state type for the t1 pack sequencer
package pk_t1_pack_ctrl_pkg;
  localparam int N = 256;
  localparam int T1_BITS = 10;
  localparam int T1_GROUP = 4;
  localparam int T1_GROUP_BYTES = 5;
  localparam int T1_POLY_BYTES = 320;
  typedef enum logic [2:0] {IDLE, FETCH, EMIT, DRAIN, DONE} state_t;
endpackage

// File: rtl/t1_group_pack.sv
// t1_group_pack: packs four 10-bit t1 coefficients into 5 bytes (byte 0 in bits [7:0])
//   coefs in  40  {a3, a2, a1, a0}, 10 bits each
//   bytes out 40  {b4, b3, b2, b1, b0}
module t1_group_pack
  import pk_t1_pack_ctrl_pkg::*;
(
  input  logic [T1_GROUP*T1_BITS-1:0] coefs,
  output logic [T1_GROUP_BYTES*8-1:0] bytes
);
  logic [T1_BITS-1:0] a0, a1, a2, a3;
  assign {a3, a2, a1, a0} = coefs;
  assign bytes = {a3[9:2], {a3[1:0], a2[9:4]}, {a2[3:0], a1[9:6]}, {a1[5:0], a0[9:8]}, a0[7:0]};
endmodule

// File: rtl/pk_t1_pack_ctrl.sv
// pk_t1_pack_ctrl: streams K t1 polynomials from coefficient RAM as packed bytes
//   clk, rst_n              clock, async active-low reset
//   start/busy/done         pass control
//   coef_rd_en/addr/data    RAM read port, data 1 cycle after enable
//   out_data/valid/ready    byte stream
//   err                     sticky range error, only when T1_RANGE_CHECK_EN is defined
module pk_t1_pack_ctrl
  import pk_t1_pack_ctrl_pkg::*;
#(
  parameter int K = 4,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          coef_rd_en,
  output logic [AW-1:0] coef_rd_addr,
  input  logic [31:0]   coef_rd_data,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);
  localparam int NC = K * N;
  localparam int NG = K * T1_POLY_BYTES / T1_GROUP_BYTES;
  state_t state, state_nx;
  logic [AW-1:0] addr, gl, ge;
  logic [1:0] rd_left, ret_idx, res, occ;
  logic rd_v, stg_full, grp_valid;
  logic [T1_GROUP-2:0][T1_BITS-1:0] col;
  logic [T1_GROUP*T1_BITS-1:0] stg, new_raw;
  logic [T1_GROUP_BYTES*8-1:0] grp, packed_grp;
  logic [2:0] bi;
  logic acc, last_b, last_acc, grp_free, last_ret, ld_stg, ld_new, grp_start, fire;
  t1_group_pack u_pack (.coefs(stg_full ? stg : new_raw), .bytes(packed_grp));
  // Occupancy counts the group register, the staging register and groups whose
  // reads are in flight; capping it at two guarantees every returning group has a home.
  always_comb begin
    acc = grp_valid && out_ready;
    last_b = acc && bi == 3'(T1_GROUP_BYTES - 1);
    last_acc = last_b && ge == AW'(1);
    grp_free = !grp_valid || last_b;
    last_ret = rd_v && ret_idx == 2'(T1_GROUP - 1);
    new_raw = {coef_rd_data[T1_BITS-1:0], col};
    ld_stg = grp_free && stg_full;
    ld_new = grp_free && !stg_full && last_ret;
    occ = {1'b0, grp_valid} + {1'b0, stg_full} + res;
    grp_start = (state == FETCH || state == EMIT) && rd_left == 2'd0 && gl != '0 && occ < 2'd2;
    fire = state == IDLE && start;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start ? FETCH : IDLE;
      FETCH: state_nx = (ld_stg || ld_new) ? EMIT : FETCH;
      EMIT:  state_nx = gl == '0 ? DRAIN : EMIT;
      DRAIN: state_nx = last_acc ? DONE : DRAIN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == FETCH || state == EMIT || state == DRAIN;
    done = state == DONE;
    coef_rd_en = grp_start || rd_left != 2'd0;
    coef_rd_addr = addr;
    out_valid = grp_valid;
    out_data = grp[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      gl <= '0;
      ge <= '0;
      rd_left <= '0;
      rd_v <= 1'b0;
      ret_idx <= '0;
      col <= '0;
      res <= '0;
      stg <= '0;
      stg_full <= 1'b0;
      grp <= '0;
      grp_valid <= 1'b0;
      bi <= '0;
    end else begin
      if (fire) begin
        addr <= '0;
        gl <= AW'(NG);
        ge <= AW'(NG);
      end else begin
        if (coef_rd_en) addr <= addr == AW'(NC - 1) ? '0 : addr + AW'(1);
        if (grp_start) gl <= gl - AW'(1);
        if (last_b) ge <= ge - AW'(1);
      end
      rd_left <= grp_start ? 2'(T1_GROUP - 1) : rd_left != 2'd0 ? rd_left - 2'd1 : 2'd0;
      rd_v <= coef_rd_en;
      if (rd_v) ret_idx <= ret_idx + 2'd1;
      if (rd_v && !last_ret) col[ret_idx] <= coef_rd_data[T1_BITS-1:0];
      res <= res + {1'b0, grp_start} - {1'b0, last_ret};
      // A completed group bypasses staging when the group register is free and staging is empty.
      if (last_ret && !ld_new) begin
        stg <= new_raw;
        stg_full <= 1'b1;
      end else if (ld_stg) stg_full <= 1'b0;
      if (ld_stg || ld_new) begin
        grp <= packed_grp;
        grp_valid <= 1'b1;
        bi <= '0;
      end else if (acc) begin
        grp <= grp >> 8;
        bi <= bi + 3'd1;
        if (last_b) grp_valid <= 1'b0;
      end
    end
  end
`ifdef T1_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (fire) err <= 1'b0;
    else if (rd_v && |coef_rd_data[31:T1_BITS]) err <= 1'b1;
  end
`else
  logic unused_hi;
  assign unused_hi = ^coef_rd_data[31:T1_BITS];
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pk_t1_pack_ctrl.sv
// tb_pk_t1_pack_ctrl: scoreboard bench for the t1 pack sequencer
module tb_pk_t1_pack_ctrl;
  localparam int K = 4;
  localparam int AW = 10;
  localparam int NB = K * 320;
`ifdef T1_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic busy, done, coef_rd_en, out_valid, err;
  logic [AW-1:0] coef_rd_addr;
  logic [31:0] coef_rd_data = '0;
  logic [7:0] out_data;
  logic [31:0] mem [K*256];
  logic [7:0] sb [$];
  logic [7:0] grp0 [5];
  logic [AW-1:0] exp_addr = '0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int n_tests = 0, n_fail = 0, cyc = 0, s0 = 0, first_v = -1, n_bytes = 0, n_done = 0, rmode = 0, d0 = 0;

  pk_t1_pack_ctrl #(.K(K), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (coef_rd_en) coef_rd_data <= mem[coef_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (coef_rd_en) begin
        chk("rd_addr", coef_rd_addr, exp_addr);
        exp_addr = exp_addr + 1'b1;
      end
      if (out_valid && first_v < 0) first_v = cyc - s0;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("byte", out_data, sb.pop_front());
        if (n_bytes < 5) grp0[n_bytes] = out_data;
        n_bytes++;
      end
      if (done) n_done++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic push_pass;
    for (int g = 0; g < K * 64; g++) begin
      logic [9:0] a0, a1, a2, a3;
      a0 = mem[4*g][9:0];
      a1 = mem[4*g+1][9:0];
      a2 = mem[4*g+2][9:0];
      a3 = mem[4*g+3][9:0];
      sb.push_back(8'(a0));
      sb.push_back(8'((a0 >> 8) | (a1 << 2)));
      sb.push_back(8'((a1 >> 6) | (a2 << 4)));
      sb.push_back(8'((a2 >> 4) | (a3 << 6)));
      sb.push_back(8'(a3 >> 2));
    end
  endtask

  task automatic go;
    @(posedge clk);
    #1 start = 1'b1;
    s0 = cyc;
    first_v = -1;
    n_bytes = 0;
    exp_addr = '0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int c = 0;
    @(negedge clk);
    while (!done && c < max) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_rd_en"}, coef_rd_en, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_addr"}, coef_rd_addr, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    for (int j = 0; j < K * 256; j++) mem[j] = 32'h3FF;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    // all-ones pass, sink always ready: latency and throughput
    rmode = 0;
    push_pass();
    d0 = n_done;
    go();
    @(negedge clk);
    chk("busy_c1", busy, 1);
    wait_done(20000);
    chk("done_cyc", cyc - s0, 6 + NB);
    chk("first_valid", first_v, 6);
    chk("busy_at_done", busy, 0);
    chk("sb_left_a", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_cnt_a", n_done - d0, 1);
    // ascending coefficients, stray start mid-pass and in the done cycle
    for (int j = 0; j < K * 256; j++) mem[j] = (j + 1) & 32'h3FF;
    push_pass();
    d0 = n_done;
    go();
    repeat (300) @(negedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("grp0_b0", grp0[0], 8'h01);
    chk("grp0_b1", grp0[1], 8'h08);
    chk("grp0_b2", grp0[2], 8'h30);
    chk("grp0_b3", grp0[3], 8'h00);
    chk("grp0_b4", grp0[4], 8'h01);
    repeat (3) begin
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("rd_after_done", coef_rd_en, 0);
    end
    chk("done_cnt_b", n_done - d0, 1);
    chk("sb_left_b", sb.size(), 0);
    // random coefficients with junk upper bits, 30% sink duty
    for (int j = 0; j < K * 256; j++) mem[j] = $urandom();
    mem[7] = mem[7] | 32'h0001_0000;
    rmode = 1;
    push_pass();
    go();
    wait_done(20000);
    chk("sb_left_c", sb.size(), 0);
    chk("err_c", err, RC);
    // reset after 100 bytes, then a fresh full pass
    for (int j = 0; j < K * 256; j++) mem[j] = $urandom() & 32'h3FF;
    push_pass();
    go();
    @(negedge clk);
    chk("err_clr", err, 0);
    for (int c = 0; c < 20000 && n_bytes < 100; c++) @(negedge clk);
    chk("reached_100", n_bytes >= 100, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("arst");
    sb.delete();
    d0 = n_done;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_pass();
    go();
    wait_done(20000);
    repeat (3) @(negedge clk);
    chk("done_cnt_e", n_done - d0, 1);
    chk("sb_left_e", sb.size(), 0);
`ifdef T1_RANGE_CHECK_EN
    for (int j = 0; j < K * 256; j++) mem[j] = j & 32'h3FF;
    mem[5] = 32'h400;
    rmode = 0;
    push_pass();
    go();
    wait_done(20000);
    chk("err_set", err, 1);
    chk("sb_left_r", sb.size(), 0);
    mem[5] = 32'h0;
    push_pass();
    go();
    @(negedge clk);
    chk("err_clr_r", err, 0);
    wait_done(20000);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
